// File: rtl/im_sram_read_arbiter.sv
// Round-robin read arbiter sharing one item-memory SRAM port between three modality requesters.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with fixed priority 0 > 1 > 2.
module im_sram_read_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 2000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic [2:0]              ReqValid_SI,
  input  logic [3*ADDR_WIDTH-1:0] ReqAddr_DI,
  output logic [2:0]              ReqReady_SO,
  output logic [2:0]              RspValid_SO,
  input  logic [2:0]              RspReady_SI,
  output logic [3*DATA_WIDTH-1:0] RspData_DO,
  output logic                    MemReadEn_SO,
  output logic [ADDR_WIDTH-1:0]   MemAddr_DO,
  input  logic [DATA_WIDTH-1:0]   MemRdata_DI,
  output logic                    Busy_SO
);

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_HOLD     = 2'd2
  } slot_state_e;

  logic [2:0]            eligible_s;
  logic [2:0]            grant_s;
  logic                  grant_any_s;
  logic [1:0]            grant_id_s;
  logic [2:0]            slot_busy_s;
  logic                  cap_vld_s;
  logic [1:0]            cap_id_s;
  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [1:0]            tag_id_q [READ_LATENCY];

`ifdef ARB_FIXED_PRIORITY_EN
  // Fixed priority: lowest index wins.
  always_comb begin
    grant_s = 3'b000;
    if (eligible_s[0]) begin
      grant_s = 3'b001;
    end else if (eligible_s[1]) begin
      grant_s = 3'b010;
    end else if (eligible_s[2]) begin
      grant_s = 3'b100;
    end else begin
      grant_s = 3'b000;
    end
  end
`else
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    grant_s = 3'b000;
    case (ptr_q)
      2'd1:    grant_s = eligible_s[1] ? 3'b010 : eligible_s[2] ? 3'b100 :
                         eligible_s[0] ? 3'b001 : 3'b000;
      2'd2:    grant_s = eligible_s[2] ? 3'b100 : eligible_s[0] ? 3'b001 :
                         eligible_s[1] ? 3'b010 : 3'b000;
      default: grant_s = eligible_s[0] ? 3'b001 : eligible_s[1] ? 3'b010 :
                         eligible_s[2] ? 3'b100 : 3'b000;
    endcase
  end

  // Pointer moves just past the winner; held when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_s) begin
      case (grant_id_s)
        2'd0:    ptr_d = 2'd1;
        2'd1:    ptr_d = 2'd2;
        default: ptr_d = 2'd0;
      endcase
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Winner index and SRAM address mux.
  always_comb begin
    grant_any_s = |grant_s;
    grant_id_s  = 2'd0;
    MemAddr_DO  = {ADDR_WIDTH{1'b0}};
    case (grant_s)
      3'b001:  MemAddr_DO = ReqAddr_DI[0 +: ADDR_WIDTH];
      3'b010: begin
        grant_id_s = 2'd1;
        MemAddr_DO = ReqAddr_DI[ADDR_WIDTH +: ADDR_WIDTH];
      end
      3'b100: begin
        grant_id_s = 2'd2;
        MemAddr_DO = ReqAddr_DI[2*ADDR_WIDTH +: ADDR_WIDTH];
      end
      default: MemAddr_DO = {ADDR_WIDTH{1'b0}};
    endcase
  end

  assign ReqReady_SO  = grant_s;
  assign MemReadEn_SO = grant_any_s;
  assign Busy_SO      = |slot_busy_s;
  assign cap_vld_s    = tag_vld_q[READ_LATENCY-1];
  assign cap_id_s     = tag_id_q[READ_LATENCY-1];

  // Tag pipeline mirrors the SRAM latency so returning data finds its owner.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      tag_vld_q <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_id_q[i] <= 2'd0;
      end
    end else begin
      tag_vld_q[0] <= grant_any_s;
      tag_id_q[0]  <= grant_id_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_slot
    localparam logic [1:0] SLOT_ID = 2'(k);
    slot_state_e           slot_q;
    slot_state_e           slot_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cap_s;

    assign cap_s          = cap_vld_s && (cap_id_s == SLOT_ID);
    assign eligible_s[k]  = ReqValid_SI[k] && (slot_q == SLOT_IDLE) && !Reset_RI;
    assign slot_busy_s[k] = (slot_q != SLOT_IDLE);
    assign RspValid_SO[k] = (slot_q == SLOT_HOLD);
    assign RspData_DO[k*DATA_WIDTH +: DATA_WIDTH] = data_q;

    // Slot lifecycle: accepted -> waiting for data -> held until consumed.
    always_comb begin
      slot_d = slot_q;
      case (slot_q)
        SLOT_IDLE:     slot_d = grant_s[k] ? SLOT_INFLIGHT : SLOT_IDLE;
        SLOT_INFLIGHT: slot_d = cap_s ? SLOT_HOLD : SLOT_INFLIGHT;
        SLOT_HOLD:     slot_d = RspReady_SI[k] ? SLOT_IDLE : SLOT_HOLD;
        default:       slot_d = SLOT_IDLE;
      endcase
    end

    // Slot state and holding register; data only written on its own capture.
    always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
        slot_q <= SLOT_IDLE;
        data_q <= {DATA_WIDTH{1'b0}};
      end else begin
        slot_q <= slot_d;
        if (cap_s) begin
          data_q <= MemRdata_DI;
        end
      end
    end
  end

endmodule

// File: doc/im_sram_read_arbiter.md
# im_sram_read_arbiter

Shares one single-port item-memory SRAM read port between the three modality requesters of the spatial encoder (mod1, mod2, mod3). Each requester posts a channel address and receives the addressed hypervector in a private holding register. Arbitration is round-robin. The SRAM read latency is fixed and tracked by a tag pipeline. The block sits between the encoder's per-modality address/handshake outputs and the shared iM/projM SRAM macro.

## Interface
- ADDR_WIDTH, 8, SRAM word address width (`ceilLog2(INPUT_CHANNELS)`)
- DATA_WIDTH, 2000, SRAM word width (`HV_DIMENSION`)
- READ_LATENCY, 1, cycles from MemReadEn_SO to valid MemRdata_DI; legal 1..3
- Clk_CI  in  1  clock; single clock domain
- Reset_RI  in  1  reset, synchronous, active-high
- ReqValid_SI  in  3  per-requester read request; bit k = modality k+1
- ReqAddr_DI  in  3*ADDR_WIDTH  requester k address at [k*ADDR_WIDTH +: ADDR_WIDTH]
- ReqReady_SO  out  3  request k accepted this cycle; at most one bit set
- RspValid_SO  out  3  holding register k contains valid data
- RspReady_SI  in  3  requester k consumes its response
- RspData_DO  out  3*DATA_WIDTH  holding register k at [k*DATA_WIDTH +: DATA_WIDTH]
- MemReadEn_SO  out  1  SRAM read strobe
- MemAddr_DO  out  ADDR_WIDTH  SRAM read address
- MemRdata_DI  in  DATA_WIDTH  SRAM read data, valid READ_LATENCY cycles after the strobe
- Busy_SO  out  1  any slot not IDLE

## Operation
- Each requester k has a slot FSM with three states: IDLE, INFLIGHT, HOLD.
  - IDLE -> INFLIGHT when its request is accepted.
  - INFLIGHT -> HOLD when its tagged data is captured.
  - HOLD -> IDLE on RspValid_SO[k] & RspReady_SI[k].
- Eligible requesters: ReqValid_SI[k] set and slot k IDLE. A slot in INFLIGHT or HOLD gets no grant, even if it re-requests.
- Grant is combinational. The search starts at the priority pointer and goes pointer, pointer+1, pointer+2 (mod 3). The first eligible requester wins.
- On a grant to k:
  - ReqReady_SO[k]=1, MemReadEn_SO=1, MemAddr_DO = ReqAddr k, all in the same cycle.
  - Pointer <= (k+1) mod 3.
- No eligible requester: ReqReady_SO=0, MemReadEn_SO=0, MemAddr_DO holds 0, pointer unchanged.
- Tag pipeline: READ_LATENCY stages of {valid, 2-bit id}, shifted every cycle. When the tail stage is valid, MemRdata_DI is written into holding register id and that slot moves to HOLD.
- The holding register is stable while in HOLD. Its contents are don't-care outside HOLD, but are not cleared except by reset.
- RspValid_SO[k] = (slot k == HOLD).
- Busy_SO = OR over slots of (state != IDLE).

## Timing
- Reset values:
  - All outputs 0, including RspData_DO.
  - Pointer = 0, all slots IDLE, tag pipeline empty.
- Accept in cycle 0 -> MemRdata_DI sampled in cycle READ_LATENCY -> RspValid_SO[k] high from cycle READ_LATENCY+1.
- The earliest re-accept for the same requester is the cycle after consumption.
- Back-to-back grants to different requesters in consecutive cycles are legal. The pipeline holds up to min(3, READ_LATENCY) reads in flight.
- Capture and consume never coincide on the same slot, because a slot in HOLD issues no new read.
- A capture for slot j and a grant to slot k can occur in the same cycle. They are independent and both take effect.
- Reset mid-operation: in-flight tags are dropped, and MemRdata_DI arriving after reset is ignored. RspValid_SO is 0 in the cycle after reset is asserted.
- ReqAddr_DI is sampled only in the grant cycle. Changes on non-granted requesters have no effect.

## Configuration
- ARB_FIXED_PRIORITY_EN
  - Defined: fixed priority, requester 0 > 1 > 2. The pointer register is not instantiated.
  - Undefined (default): round-robin as described above.
- Slot FSMs, the tag pipeline and the timing are identical in both builds.

## Test plan
- READ_LATENCY=1; single request mod1 addr 0x05, RspReady held 1 -> MemReadEn with addr 0x05 in cycle 0; RspValid_SO=3'b001 in cycle 2 with data = SRAM word 5; slot back to IDLE in cycle 3.
- All three requesting from reset (addrs 0x00, 0x20, 0x6D) -> grant order 0,1,2 in consecutive cycles; pointer returns to 0; three distinct responses, each with the correct data.
- Requester 0 holds HOLD with RspReady low for 10 cycles while re-requesting -> no grant to 0; requesters 1 and 2 continue to be served; data 0 stays stable.
- READ_LATENCY=3, grants to 2, 0, 1 back-to-back -> captures land in cycles 3, 4, 5 in slots 2, 0, 1 with no tag mix-up.
- Reset asserted one cycle after a grant with READ_LATENCY=2 -> no RspValid afterwards; Busy_SO=0; the next request after reset is served normally.
- ARB_FIXED_PRIORITY_EN defined, all three requesting continuously with immediate consume -> requester 0 wins every eligible cycle; requester 2 is granted only while 0 and 1 are INFLIGHT or HOLD.
